multi_channel_queue: RTL and testbench
======================================

Name: multi_channel_queue

Overview:
Parametrised successor of the single-channel scheduler queue. It holds NUM_CHANNELS independent FIFOs in one shared storage array, one per requesting core. Each channel has its own occupancy counter, full/empty flags, overflow/underflow error flags, and a hysteresis throttle ("kill") output. The block sits between the request classifier and the EDF arbiter in MemorEDF.

Parameters:
DATA_SIZE, 8, width of one stored entry
QUEUE_LENGTH, 4, entries per channel; any value >= 2, power of two not required
NUM_CHANNELS, 4, number of independent channels, >= 1
REGISTER_SIZE, 32, width of threshold registers
CH_W, $clog2(NUM_CHANNELS) (min 1), derived; width of channel-id ports

Ports:
clock  in  1  single clock; all state updates on rising edge
reset  in  1  synchronous, active-high reset
high_threshold  in  NUM_CHANNELS*REGISTER_SIZE  per-channel kill-assert level; channel c at [c*REGISTER_SIZE +: REGISTER_SIZE]
low_threshold  in  NUM_CHANNELS*REGISTER_SIZE  per-channel kill-release level, same packing
push_valid  in  1  write request
push_channel  in  CH_W  target channel of the write
push_data  in  DATA_SIZE  entry to store
pop_valid  in  1  read request
pop_channel  in  CH_W  channel to read
pop_data  out  DATA_SIZE  entry read, registered
pop_data_valid  out  1  pop_data is valid this cycle
empty  out  NUM_CHANNELS  per-channel empty flag
full  out  NUM_CHANNELS  per-channel full flag
kill_the_core  out  NUM_CHANNELS  per-channel throttle
overflow  out  NUM_CHANNELS  sticky; a push was dropped
underflow  out  NUM_CHANNELS  sticky; a pop was ignored

Behaviour:
- Reset values: all counters, head and tail pointers 0; empty all 1; full, kill_the_core, overflow, underflow all 0; pop_data 0; pop_data_valid 0. Reset takes priority over every concurrent push or pop; an in-flight pop_data_valid is cleared.
- Storage: NUM_CHANNELS*QUEUE_LENGTH entries. Channel c occupies the region starting at base c*QUEUE_LENGTH. Head and tail are per-channel pointers of width $clog2(QUEUE_LENGTH). A pointer wraps from QUEUE_LENGTH-1 to 0 by explicit compare, never by modulo of a non-power-of-two value.
- Push: accepted iff push_valid and !full[ch], or if a pop on the same channel is accepted in the same cycle. On accept: write push_data at tail, tail increments, counter increments.
- Push to a full channel without a same-channel pop: the push is dropped, overflow[ch] is set, and no state changes.
- Pop: accepted iff pop_valid and !empty[ch]. On accept: the entry at head appears on pop_data in the next cycle with pop_data_valid=1 (1-cycle latency); head increments, counter decrements.
- Pop on an empty channel: ignored, underflow[ch] is set, and pop_data_valid=0 next cycle. A push on the same empty channel in the same cycle does not make the pop legal.
- pop_data holds its last value when pop_data_valid=0.
- Simultaneous accepted push and pop on the same channel: counter, full and empty are unchanged; both pointers advance. Read-before-write applies to the storage array.
- Pushes and pops on different channels update independently.
- full[c] = (counter==QUEUE_LENGTH); empty[c] = (counter==0). Both are registered and updated in the same cycle as the counter. The counter is $clog2(QUEUE_LENGTH+1) bits wide.
- Kill FSM per channel, states NORMAL and THROTTLED, evaluated on the post-update counter and registered:
  - NORMAL -> THROTTLED when high>0 and counter>=high.
  - THROTTLED -> NORMAL when high==0 or counter<=low.
  - kill_the_core[c]=1 exactly in THROTTLED.
  - If low>=high, release takes priority and the FSM stays NORMAL.
- overflow and underflow are cleared only by reset.

Optional Feature:
Macro QUEUE_WATERMARK_EN.
- When defined: adds output max_occupancy (NUM_CHANNELS*$clog2(QUEUE_LENGTH+1) bits). Each field records the highest counter value reached by that channel since reset, updated the cycle after the counter. The output is 0 at reset.
- When undefined: the port and its registers do not exist. All other behaviour is identical.

Test Plan:
- Reset, then push 0xA1, 0xA2, 0xA3 on ch1; pop ch1 three times -> pop_data 0xA1, 0xA2, 0xA3, each one cycle after its pop; empty[1]=1 at the end; other channels untouched.
- QUEUE_LENGTH=5: push 5 entries on ch0 -> full[0]=1. A 6th push -> dropped, overflow[0]=1. Pop/push 12 more entries -> data in order across pointer wrap.
- Channel full, with simultaneous push 0x55 and pop on ch2 -> counter stays 4, full stays 1, no overflow, oldest entry output; 0x55 is later read last.
- high=3, low=1 on ch3: push 3 -> kill[3]=1. Pop to 2 -> still 1. Pop to 1 -> kill[3]=0. With high=0, push to full -> kill stays 0.
- Pop on empty ch0 while pushing ch0 -> underflow[0]=1, pop_data_valid=0, counter becomes 1.
- Reset asserted mid-traffic with pop_data_valid pending -> all outputs at reset values next cycle. With QUEUE_WATERMARK_EN defined, max_occupancy=0 after reset and equals the peak count after refill.

Source files
------------

// File: rtl/multi_channel_queue.sv
// multi_channel_queue: NUM_CHANNELS independent FIFOs sharing one storage
// array, each with occupancy flags, sticky error flags and a hysteresis
// throttle ("kill") FSM.
// Optional macro QUEUE_WATERMARK_EN adds the max_occupancy output.
//
// Kill FSM (one per channel):
//   state          | meaning
//   KILL_NORMAL    | channel below high threshold, core not throttled
//   KILL_THROTTLED | occupancy reached high threshold, kill_the_core asserted
module multi_channel_queue #(
  parameter int DATA_SIZE     = 8,
  parameter int QUEUE_LENGTH  = 4,
  parameter int NUM_CHANNELS  = 4,
  parameter int REGISTER_SIZE = 32,
  parameter int CH_W          = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1
) (
  input  logic                                  clock,
  input  logic                                  reset,
  input  logic [NUM_CHANNELS*REGISTER_SIZE-1:0] high_threshold,
  input  logic [NUM_CHANNELS*REGISTER_SIZE-1:0] low_threshold,
  input  logic                                  push_valid,
  input  logic [CH_W-1:0]                       push_channel,
  input  logic [DATA_SIZE-1:0]                  push_data,
  input  logic                                  pop_valid,
  input  logic [CH_W-1:0]                       pop_channel,
  output logic [DATA_SIZE-1:0]                  pop_data,
  output logic                                  pop_data_valid,
  output logic [NUM_CHANNELS-1:0]               empty,
  output logic [NUM_CHANNELS-1:0]               full,
  output logic [NUM_CHANNELS-1:0]               kill_the_core,
  output logic [NUM_CHANNELS-1:0]               overflow,
  output logic [NUM_CHANNELS-1:0]               underflow
`ifdef QUEUE_WATERMARK_EN
  ,output logic [NUM_CHANNELS*$clog2(QUEUE_LENGTH+1)-1:0] max_occupancy
`endif
);

  localparam int PTR_W = $clog2(QUEUE_LENGTH);
  localparam int CNT_W = $clog2(QUEUE_LENGTH + 1);
  localparam int DEPTH = NUM_CHANNELS * QUEUE_LENGTH;
  localparam int IDX_W = $clog2(DEPTH);

  typedef enum logic {KILL_NORMAL = 1'b0, KILL_THROTTLED = 1'b1} kill_state_e;

  logic [DATA_SIZE-1:0]    mem_q [DEPTH];
  logic [DATA_SIZE-1:0]    mem_d [DEPTH];
  logic [PTR_W-1:0]        head_q [NUM_CHANNELS];
  logic [PTR_W-1:0]        head_d [NUM_CHANNELS];
  logic [PTR_W-1:0]        tail_q [NUM_CHANNELS];
  logic [PTR_W-1:0]        tail_d [NUM_CHANNELS];
  logic [CNT_W-1:0]        cnt_q [NUM_CHANNELS];
  logic [CNT_W-1:0]        cnt_d [NUM_CHANNELS];
  kill_state_e             kill_q [NUM_CHANNELS];
  kill_state_e             kill_d [NUM_CHANNELS];
  logic [NUM_CHANNELS-1:0] empty_q, empty_d, full_q, full_d;
  logic [NUM_CHANNELS-1:0] overflow_q, overflow_d, underflow_q, underflow_d;
  logic [DATA_SIZE-1:0]    pop_data_q, pop_data_d;
  logic                    pop_data_valid_q, pop_data_valid_d;

  logic                     push_hit, pop_hit, push_acc, pop_acc;
  logic                     kill_set, kill_clr;
  logic [CNT_W-1:0]         cnt_nxt;
  logic [REGISTER_SIZE-1:0] cnt_ext, thr_high, thr_low;

  // Pointers wrap by explicit compare so QUEUE_LENGTH need not be a power of two.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(QUEUE_LENGTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Per-channel accept decisions, storage write/read and next-state for counters, flags and kill FSM.
  always_comb begin
    mem_d            = mem_q;
    head_d           = head_q;
    tail_d           = tail_q;
    cnt_d            = cnt_q;
    kill_d           = kill_q;
    empty_d          = empty_q;
    full_d           = full_q;
    overflow_d       = overflow_q;
    underflow_d      = underflow_q;
    pop_data_d       = pop_data_q;
    pop_data_valid_d = 1'b0;
    push_hit = 1'b0;
    pop_hit  = 1'b0;
    push_acc = 1'b0;
    pop_acc  = 1'b0;
    kill_set = 1'b0;
    kill_clr = 1'b0;
    cnt_nxt  = '0;
    cnt_ext  = '0;
    thr_high = '0;
    thr_low  = '0;
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      push_hit = push_valid && (push_channel == CH_W'(c));
      pop_hit  = pop_valid && (pop_channel == CH_W'(c));
      pop_acc  = pop_hit && !empty_q[c];
      // A same-channel pop frees a slot, so a full channel can still accept.
      push_acc = push_hit && (!full_q[c] || pop_acc);

      if (push_hit && !push_acc) overflow_d[c] = 1'b1;
      if (pop_hit && !pop_acc) underflow_d[c] = 1'b1;

      // Read uses mem_q, so a same-slot write this cycle is not visible (read-before-write).
      if (pop_acc) begin
        pop_data_d       = mem_q[IDX_W'(c * QUEUE_LENGTH) + IDX_W'(head_q[c])];
        pop_data_valid_d = 1'b1;
        head_d[c]        = ptr_inc(head_q[c]);
      end
      if (push_acc) begin
        mem_d[IDX_W'(c * QUEUE_LENGTH) + IDX_W'(tail_q[c])] = push_data;
        tail_d[c] = ptr_inc(tail_q[c]);
      end

      cnt_nxt = cnt_q[c];
      if (push_acc && !pop_acc) cnt_nxt = cnt_q[c] + CNT_W'(1);
      if (pop_acc && !push_acc) cnt_nxt = cnt_q[c] - CNT_W'(1);
      cnt_d[c]   = cnt_nxt;
      full_d[c]  = (cnt_nxt == CNT_W'(QUEUE_LENGTH));
      empty_d[c] = (cnt_nxt == '0);

      // Hysteresis on the post-update count; an inverted window (low>=high) never throttles.
      thr_high = high_threshold[c*REGISTER_SIZE +: REGISTER_SIZE];
      thr_low  = low_threshold[c*REGISTER_SIZE +: REGISTER_SIZE];
      cnt_ext  = REGISTER_SIZE'(cnt_nxt);
      kill_clr = (thr_high == '0) || (cnt_ext <= thr_low) || (thr_low >= thr_high);
      kill_set = !kill_clr && (cnt_ext >= thr_high);
      case (kill_q[c])
        KILL_NORMAL:    if (kill_set) kill_d[c] = KILL_THROTTLED;
        KILL_THROTTLED: if (kill_clr) kill_d[c] = KILL_NORMAL;
        default:        kill_d[c] = KILL_NORMAL;
      endcase
    end
  end

  // Storage array carries no reset; validity is tracked by the counters.
  always_ff @(posedge clock) begin
    mem_q <= mem_d;
  end

  // Control state register with synchronous reset taking priority over traffic.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int c = 0; c < NUM_CHANNELS; c++) begin
        head_q[c] <= '0;
        tail_q[c] <= '0;
        cnt_q[c]  <= '0;
        kill_q[c] <= KILL_NORMAL;
      end
      empty_q          <= '1;
      full_q           <= '0;
      overflow_q       <= '0;
      underflow_q      <= '0;
      pop_data_q       <= '0;
      pop_data_valid_q <= 1'b0;
    end else begin
      head_q           <= head_d;
      tail_q           <= tail_d;
      cnt_q            <= cnt_d;
      kill_q           <= kill_d;
      empty_q          <= empty_d;
      full_q           <= full_d;
      overflow_q       <= overflow_d;
      underflow_q      <= underflow_d;
      pop_data_q       <= pop_data_d;
      pop_data_valid_q <= pop_data_valid_d;
    end
  end

  // Output drive from registered state.
  always_comb begin
    kill_the_core = '0;
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      kill_the_core[c] = (kill_q[c] == KILL_THROTTLED);
    end
  end

  assign pop_data       = pop_data_q;
  assign pop_data_valid = pop_data_valid_q;
  assign empty          = empty_q;
  assign full           = full_q;
  assign overflow       = overflow_q;
  assign underflow      = underflow_q;

`ifdef QUEUE_WATERMARK_EN
  logic [CNT_W-1:0] max_q [NUM_CHANNELS];
  logic [CNT_W-1:0] max_d [NUM_CHANNELS];

  // Peak tracking follows the registered counter, so it lags the count by one cycle.
  always_comb begin
    max_d         = max_q;
    max_occupancy = '0;
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      if (cnt_q[c] > max_q[c]) max_d[c] = cnt_q[c];
      max_occupancy[c*CNT_W +: CNT_W] = max_q[c];
    end
  end

  // Watermark register.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int c = 0; c < NUM_CHANNELS; c++) max_q[c] <= '0;
    end else begin
      max_q <= max_d;
    end
  end
`endif

endmodule

// File: tb/tb_multi_channel_queue.sv
// Self-checking bench for multi_channel_queue with a queue-based reference model.
module tb_multi_channel_queue;

  localparam int DS    = 8;
  localparam int QL    = 5;
  localparam int NC    = 4;
  localparam int RS    = 32;
  localparam int CH_W  = 2;
  localparam int CNT_W = 3;

  logic             clock = 1'b0;
  logic             reset;
  logic [NC*RS-1:0] high_threshold;
  logic [NC*RS-1:0] low_threshold;
  logic             push_valid;
  logic [CH_W-1:0]  push_channel;
  logic [DS-1:0]    push_data;
  logic             pop_valid;
  logic [CH_W-1:0]  pop_channel;
  logic [DS-1:0]    pop_data;
  logic             pop_data_valid;
  logic [NC-1:0]    empty, full, kill_the_core, overflow, underflow;
`ifdef QUEUE_WATERMARK_EN
  logic [NC*CNT_W-1:0] max_occupancy;
`endif

  multi_channel_queue #(
    .DATA_SIZE(DS), .QUEUE_LENGTH(QL), .NUM_CHANNELS(NC), .REGISTER_SIZE(RS), .CH_W(CH_W)
  ) dut (
    .clock(clock), .reset(reset),
    .high_threshold(high_threshold), .low_threshold(low_threshold),
    .push_valid(push_valid), .push_channel(push_channel), .push_data(push_data),
    .pop_valid(pop_valid), .pop_channel(pop_channel),
    .pop_data(pop_data), .pop_data_valid(pop_data_valid),
    .empty(empty), .full(full), .kill_the_core(kill_the_core),
    .overflow(overflow), .underflow(underflow)
`ifdef QUEUE_WATERMARK_EN
    ,.max_occupancy(max_occupancy)
`endif
  );

  always #5 clock = ~clock;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  logic [DS-1:0] mq [NC][$];
  bit            m_kill [NC];
  bit [NC-1:0]   m_ovf, m_udf;
  logic [DS-1:0] m_data;
  bit            m_valid;
  int            m_max [NC];
  int            hi [NC];
  int            lo [NC];

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, obs, exp);
    end
  endtask

  task automatic check_outputs();
    logic [NC-1:0] e_empty, e_full, e_kill;
    logic [NC*CNT_W-1:0] e_max;
    for (int c = 0; c < NC; c++) begin
      e_empty[c] = (mq[c].size() == 0);
      e_full[c]  = (mq[c].size() == QL);
      e_kill[c]  = m_kill[c];
      e_max[c*CNT_W +: CNT_W] = CNT_W'(m_max[c]);
    end
    check_eq("pop_data_valid", pop_data_valid, m_valid);
    check_eq("pop_data", pop_data, m_data);
    check_eq("empty", empty, e_empty);
    check_eq("full", full, e_full);
    check_eq("kill_the_core", kill_the_core, e_kill);
    check_eq("overflow", overflow, m_ovf);
    check_eq("underflow", underflow, m_udf);
`ifdef QUEUE_WATERMARK_EN
    check_eq("max_occupancy", max_occupancy, e_max);
`endif
  endtask

  task automatic set_thr(input int c, input int h, input int l);
    hi[c] = h;
    lo[c] = l;
    high_threshold[c*RS +: RS] = h;
    low_threshold[c*RS +: RS]  = l;
  endtask

  // One clock of traffic: drive inputs, advance the model, check after the edge.
  task automatic cycle(input bit pv, input int pc, input logic [DS-1:0] pd,
                       input bit ov, input int oc);
    bit pop_ok, push_ok;
    int sz;
    push_valid   = pv;
    push_channel = CH_W'(pc);
    push_data    = pd;
    pop_valid    = ov;
    pop_channel  = CH_W'(oc);
    for (int c = 0; c < NC; c++)
      if (mq[c].size() > m_max[c]) m_max[c] = mq[c].size();
    pop_ok  = ov && (mq[oc].size() > 0);
    push_ok = pv && ((mq[pc].size() < QL) || (pop_ok && oc == pc));
    if (ov && !pop_ok) m_udf[oc] = 1'b1;
    if (pv && !push_ok) m_ovf[pc] = 1'b1;
    m_valid = pop_ok;
    if (pop_ok) m_data = mq[oc].pop_front();
    if (push_ok) mq[pc].push_back(pd);
    for (int c = 0; c < NC; c++) begin
      sz = mq[c].size();
      if (!m_kill[c]) begin
        if (hi[c] > 0 && sz >= hi[c] && lo[c] < hi[c]) m_kill[c] = 1'b1;
      end else begin
        if (hi[c] == 0 || sz <= lo[c] || lo[c] >= hi[c]) m_kill[c] = 1'b0;
      end
    end
    @(posedge clock);
    #1;
    check_outputs();
    @(negedge clock);
  endtask

  task automatic idle();
    cycle(1'b0, 0, 8'h00, 1'b0, 0);
  endtask

  // Reset with concurrent traffic, which must be ignored.
  task automatic do_reset();
    reset        = 1'b1;
    push_valid   = 1'b1;
    push_channel = CH_W'($urandom_range(0, NC-1));
    push_data    = DS'($urandom);
    pop_valid    = 1'b1;
    pop_channel  = CH_W'($urandom_range(0, NC-1));
    for (int c = 0; c < NC; c++) begin
      mq[c].delete();
      m_kill[c] = 1'b0;
      m_max[c]  = 0;
    end
    m_ovf   = '0;
    m_udf   = '0;
    m_data  = '0;
    m_valid = 1'b0;
    @(posedge clock);
    #1;
    check_outputs();
    @(negedge clock);
    reset = 1'b0;
  endtask

  initial begin
    reset          = 1'b1;
    high_threshold = '0;
    low_threshold  = '0;
    push_valid     = 1'b0;
    push_channel   = '0;
    push_data      = '0;
    pop_valid      = 1'b0;
    pop_channel    = '0;
    for (int c = 0; c < NC; c++) set_thr(c, 0, 0);
    @(negedge clock);
    do_reset();

    // Basic in-order traffic on ch1
    for (int i = 1; i <= 3; i++) cycle(1'b1, 1, DS'(8'hA0 + i), 1'b0, 0);
    for (int i = 0; i < 3; i++) cycle(1'b0, 0, 8'h00, 1'b1, 1);
    idle();

    // Fill ch0, overflow, then wrap pointers with simultaneous push/pop on a full channel
    for (int i = 0; i < QL + 1; i++) cycle(1'b1, 0, DS'(8'h10 + i), 1'b0, 0);
    for (int i = 0; i < 12; i++) cycle(1'b1, 0, DS'(8'h20 + i), 1'b1, 0);
    for (int i = 0; i < QL; i++) cycle(1'b0, 0, 8'h00, 1'b1, 0);
    idle();

    // Full ch2 with simultaneous push 0x55 and pop; 0x55 drains last
    for (int i = 0; i < QL; i++) cycle(1'b1, 2, DS'(8'h30 + i), 1'b0, 0);
    cycle(1'b1, 2, 8'h55, 1'b1, 2);
    for (int i = 0; i < QL; i++) cycle(1'b0, 0, 8'h00, 1'b1, 2);

    // Hysteresis on ch3: high=3, low=1, then high=0 disables throttling
    set_thr(3, 3, 1);
    for (int i = 0; i < 3; i++) cycle(1'b1, 3, DS'(8'h40 + i), 1'b0, 0);
    cycle(1'b0, 0, 8'h00, 1'b1, 3);
    cycle(1'b0, 0, 8'h00, 1'b1, 3);
    set_thr(3, 0, 1);
    for (int i = 0; i < QL; i++) cycle(1'b1, 3, DS'(8'h48 + i), 1'b0, 0);
    for (int i = 0; i < QL; i++) cycle(1'b0, 0, 8'h00, 1'b1, 3);
    // Inverted window never throttles
    set_thr(3, 2, 4);
    for (int i = 0; i < 3; i++) cycle(1'b1, 3, DS'(8'h50 + i), 1'b0, 0);

    // Pop on empty ch0 together with a push to ch0
    cycle(1'b1, 0, 8'h77, 1'b1, 0);
    cycle(1'b0, 0, 8'h00, 1'b1, 0);

    // Reset with a pop result in flight, then refill for the watermark
    cycle(1'b1, 1, 8'h61, 1'b0, 0);
    cycle(1'b1, 1, 8'h62, 1'b1, 1);
    do_reset();
    for (int i = 0; i < 3; i++) cycle(1'b1, 2, DS'(8'h70 + i), 1'b0, 0);
    idle();
    idle();

    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      if (n % 200 == 0)
        for (int c = 0; c < NC; c++) set_thr(c, $urandom_range(0, QL + 1), $urandom_range(0, QL));
      if ($urandom_range(0, 199) == 0) do_reset();
      else cycle(($urandom_range(0, 2) != 0), $urandom_range(0, NC-1), DS'($urandom),
                 ($urandom_range(0, 2) != 0), $urandom_range(0, NC-1));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
